xgriscv_mem_arbiter: RTL and testbench
======================================

// Module: xgriscv_mem_arbiter
// PURPOSE
//  Shares one single-port memory bus between instruction fetch (IF) and the MEM-stage load/store path.
//  Arbitrates, builds byte enables/write data from swhb, aligns and extends load data from lwhb/lunsigned.
//  Raises completion pulses that the pipeline uses as stall release.
//  One outstanding bus transaction at a time; starvation guard for IF.
// PARAMETERS
//  AW           32  address width
//  STARVE_LIMIT 4   consecutive data grants while IF waits before IF is forced to win; 0 = data always wins
// PORTS
//  clk          in  1   clock, rising edge
//  reset        in  1   asynchronous, active-low reset (0 = reset)
//  if_req       in  1   fetch request; held with if_addr until if_rvalid
//  if_addr      in  AW  fetch address (word aligned)
//  if_flush     in  1   discard in-flight fetch (redirect)
//  if_rvalid    out 1   1-cycle pulse: if_rdata valid
//  if_rdata     out 32  fetched instruction
//  d_req        in  1   load/store request; fields held until d_done
//  d_we         in  1   1 = store (memwrite)
//  d_addr       in  AW  byte address
//  d_wdata      in  32  store data, LSB-justified
//  d_lwhb       in  2   load size: 11 w, 10 h, 01 b
//  d_swhb       in  2   store size: 11 w, 10 h, 01 b
//  d_lunsigned  in  1   zero-extend load
//  d_done       out 1   1-cycle pulse: access complete
//  d_rdata      out 32  aligned, extended load data (valid with d_done)
//  d_misalign   out 1   with d_done: access misaligned, not issued
//  m_req        out 1   bus request; held stable until m_gnt
//  m_we         out 1   bus write
//  m_addr       out AW  word address (addr[1:0] forced 0)
//  m_be         out 4   byte enables
//  m_wdata      out 32  lane-replicated write data
//  m_gnt        in  1   bus accepts address phase
//  m_rvalid     in  1   response/write-ack; >=1 cycle after m_gnt
//  m_rdata      in  32  read data
// BEHAVIOUR
//  Reset: state IDLE, streak counter 0, drop flag 0, all outputs 0.
//  FSM: IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT.
//   IDLE: only if_req -> I_ADDR; only d_req -> D_ADDR (or misalign path); both -> D_ADDR unless streak==STARVE_LIMIT!=0, then I_ADDR.
//   Request fields are latched on leaving IDLE.
//   X_ADDR: m_req=1 with registered fields; m_gnt -> X_WAIT.
//   X_WAIT: m_rvalid -> IDLE; the completion pulse is combinational in the same cycle.
//  Minimum latency: req at cycle 0, m_req at cycle 1, m_gnt at 1, m_rvalid at 2, pulse at 2. Next arbitration at cycle 3.
//  Streak: +1 on each data grant while if_req=1 (saturates at STARVE_LIMIT); cleared on IF grant.
//  Misalign: word with addr[1:0]!=0, or half with addr[0]!=0.
//   No bus access; d_done=d_misalign=1 one cycle after IDLE accept; FSM stays IDLE.
//  Store: be b=0001<<a, h=0011<<a, w=1111 (a=addr[1:0]); wdata b={4{w[7:0]}}, h={2{w[15:0]}}, w=w.
//  Load: r=m_rdata>>(8*a); b/h sign- or zero-extended per d_lunsigned; w unchanged.
//  Flush: if_flush in I_ADDR/I_WAIT sets drop. The bus transaction still completes (m_req never withdrawn).
//   if_rvalid is suppressed for it; drop clears on return to IDLE. Flush in IDLE: no effect.
//   Flush coinciding with m_rvalid: the pulse is suppressed.
//  d_req/if_req deasserted while pending: violation, not handled.
//  Reset mid-transaction: FSM abandons it; memory shares the same reset.
// STRUCTURE
//  xgriscv_defines.v: state encodings, size codes (LWHB_W/H/B), BE patterns.
//  Sub-module xgriscv_lsu_align: combinational be/wdata generation, load shift/extend, misalign detect.
// TESTING
//  IF only: if_addr=0x100, gnt cycle 1, rvalid cycle 2 rdata=0x00500093 -> if_rvalid@2, if_rdata=0x00500093.
//  Simultaneous if_req+d_req (lw 0x200), STARVE_LIMIT=4 -> data first; IF granted after data completes.
//  Continuous d_req plus if_req, STARVE_LIMIT=2 -> grant order D,D,I,D,D,I.
//  sb 0x203 wdata=0xAB -> m_be=1000, m_wdata=0xABABABAB.
//  lh 0x202 m_rdata=0x8001xxxx -> d_rdata=0xFFFF8001; lhu -> 0x00008001.
//  lw 0x201 -> d_done & d_misalign@+1, no m_req. if_flush during I_WAIT -> no if_rvalid, FSM returns to IDLE.
//  Reset low during D_WAIT -> m_req=0, IDLE.

Source files
------------

// File: rtl/xgriscv_mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory bus arbiter: access size codes,
// byte-enable base patterns and arbiter FSM states.
package xgriscv_mem_arbiter_pkg;

    localparam logic [1:0] SizeB = 2'b01;
    localparam logic [1:0] SizeH = 2'b10;
    localparam logic [1:0] SizeW = 2'b11;

    localparam logic [3:0] BeByte = 4'b0001;
    localparam logic [3:0] BeHalf = 4'b0011;
    localparam logic [3:0] BeWord = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StIAddr,
        StIWait,
        StDAddr,
        StDWait
    } arb_state_e;

endpackage

// File: rtl/xgriscv_lsu_align.sv
// Load/store lane handling: store byte enables and lane-replicated data,
// misalignment detection, and load data shift plus sign/zero extension.
module xgriscv_lsu_align
    import xgriscv_mem_arbiter_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic        st_we,
    input  logic [1:0]  st_swhb,
    input  logic [1:0]  st_lwhb,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    output logic        st_misalign,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_lwhb,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [1:0]  acc_size;
    logic [31:0] ld_shift;

    always_comb begin
        st_be        = BeWord;
        st_wdata_rep = st_wdata;
        case (st_swhb)
            SizeB: begin
                st_be        = BeByte << st_off;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            SizeH: begin
                st_be        = BeHalf << st_off;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase

        // Alignment is judged against the size of the access actually requested.
        acc_size    = st_we ? st_swhb : st_lwhb;
        st_misalign = ((acc_size == SizeW) && (st_off != 2'b00)) ||
                      ((acc_size == SizeH) && st_off[0]);

        ld_shift = ld_raw >> {ld_off, 3'b000};
        ld_data  = ld_shift;
        case (ld_lwhb)
            SizeB:   ld_data = {{24{~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
            SizeH:   ld_data = {{16{~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/xgriscv_mem_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and the MEM-stage
// load/store path; one outstanding transaction, with a fetch starvation guard.
module xgriscv_mem_arbiter
    import xgriscv_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [1:0]    d_lwhb,
    input  logic [1:0]    d_swhb,
    input  logic          d_lunsigned,
    output logic          d_done,
    output logic [31:0]   d_rdata,
    output logic          d_misalign,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [3:0]    m_be,
    output logic [31:0]   m_wdata,
    input  logic          m_gnt,
    input  logic          m_rvalid,
    input  logic [31:0]   m_rdata
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] StreakMax = SW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          drop_q, drop_d;
    logic          mis_q, mis_d;
    logic          we_q, lunsigned_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [1:0]    lwhb_q;
    logic          lat_if, lat_d, starve;

    logic [3:0]    al_be;
    logic [31:0]   al_wdata, al_rdata;
    logic          al_misalign;

    xgriscv_lsu_align u_align (
        .st_off       (d_addr[1:0]),
        .st_we        (d_we),
        .st_swhb      (d_swhb),
        .st_lwhb      (d_lwhb),
        .st_wdata     (d_wdata),
        .st_be        (al_be),
        .st_wdata_rep (al_wdata),
        .st_misalign  (al_misalign),
        .ld_off       (addr_q[1:0]),
        .ld_lwhb      (lwhb_q),
        .ld_unsigned  (lunsigned_q),
        .ld_raw       (m_rdata),
        .ld_data      (al_rdata)
    );

    assign starve = (STARVE_LIMIT != 0) && (streak_q == StreakMax);

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        drop_d     = drop_q;
        mis_d      = 1'b0;
        lat_if     = 1'b0;
        lat_d      = 1'b0;
        m_req      = 1'b0;
        if_rvalid  = 1'b0;
        d_done     = 1'b0;
        d_misalign = 1'b0;
        case (state_q)
            StIdle: begin
                drop_d     = 1'b0;
                d_done     = mis_q;
                d_misalign = mis_q;
                // The misalign pulse cycle blocks arbitration: d_req is still held.
                if (!mis_q) begin
                    if (d_req && !(if_req && starve)) begin
                        if (if_req && (streak_q != StreakMax)) begin
                            streak_d = streak_q + 1'b1;
                        end
                        if (al_misalign) begin
                            mis_d = 1'b1;
                        end else begin
                            lat_d   = 1'b1;
                            state_d = StDAddr;
                        end
                    end else if (if_req) begin
                        streak_d = '0;
                        lat_if   = 1'b1;
                        state_d  = StIAddr;
                    end
                end
            end
            StIAddr: begin
                m_req = 1'b1;
                if (if_flush) drop_d = 1'b1;
                if (m_gnt) state_d = StIWait;
            end
            StIWait: begin
                if (if_flush) drop_d = 1'b1;
                if (m_rvalid) begin
                    if_rvalid = !drop_q && !if_flush;
                    drop_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            StDAddr: begin
                m_req = 1'b1;
                if (m_gnt) state_d = StDWait;
            end
            StDWait: begin
                if (m_rvalid) begin
                    d_done  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign if_rdata = if_rvalid ? m_rdata : 32'h0;
    assign d_rdata  = ((state_q == StDWait) && m_rvalid) ? al_rdata : 32'h0;
    assign m_we     = we_q;
    assign m_addr   = {addr_q[AW-1:2], 2'b00};
    assign m_be     = be_q;
    assign m_wdata  = wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            streak_q    <= '0;
            drop_q      <= 1'b0;
            mis_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            lwhb_q      <= 2'b00;
            lunsigned_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            drop_q   <= drop_d;
            mis_q    <= mis_d;
            if (lat_d) begin
                we_q        <= d_we;
                addr_q      <= d_addr;
                be_q        <= al_be;
                wdata_q     <= al_wdata;
                lwhb_q      <= d_lwhb;
                lunsigned_q <= d_lunsigned;
            end else if (lat_if) begin
                we_q    <= 1'b0;
                addr_q  <= if_addr;
                be_q    <= BeWord;
                wdata_q <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_xgriscv_mem_arbiter.sv
// Directed bench for xgriscv_mem_arbiter: a bus responder with memory, and a
// scoreboard of expected completion pulses checked as the DUT produces them.
module tb_xgriscv_mem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned LIMIT = 2;
    localparam logic [1:0] SZ_B = 2'b01, SZ_H = 2'b10, SZ_W = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_flush, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          d_req, d_we, d_lunsigned, d_done, d_misalign;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic [1:0]    d_lwhb, d_swhb;
    logic          m_req, m_we, m_gnt, m_rvalid;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_be;
    logic [31:0]   m_wdata, m_rdata;

    xgriscv_mem_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_flush    (if_flush),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_lwhb      (d_lwhb),
        .d_swhb      (d_swhb),
        .d_lunsigned (d_lunsigned),
        .d_done      (d_done),
        .d_rdata     (d_rdata),
        .d_misalign  (d_misalign),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_be        (m_be),
        .m_wdata     (m_wdata),
        .m_gnt       (m_gnt),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Bus responder: grant when enabled, respond the cycle after grant unless held.
    logic        gnt_en = 1'b1;
    logic        hold_rv = 1'b0;
    logic        pend;
    logic [31:0] rd_q;
    logic [31:0] mem [0:1023];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        merge = old;
        for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = wd[8*b +: 8];
    endfunction

    assign m_gnt    = m_req & gnt_en;
    assign m_rvalid = pend & ~hold_rv;
    assign m_rdata  = rd_q;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend        <= 1'b0;
            rd_q        <= 32'h0;
            mem[10'h40] <= 32'h00500093;
            mem[10'h80] <= 32'h80011234;
            mem[10'hC0] <= 32'h11223344;
        end else if (m_req && m_gnt) begin
            pend <= 1'b1;
            rd_q <= mem[m_addr[11:2]];
            if (m_we) mem[m_addr[11:2]] <= merge(mem[m_addr[11:2]], m_wdata, m_be);
        end else if (m_rvalid) begin
            pend <= 1'b0;
        end
    end

    // Scoreboard and monitor.
    typedef struct {
        bit          chk;
        logic [31:0] rdata;
        logic        mis;
    } dexp_t;

    dexp_t       exp_d[$];
    logic [31:0] exp_if[$];
    bit          glog[$];
    int          cyc = 0;
    int          if_cyc, d_cyc, mreq_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (m_req) mreq_cnt++;
            if (m_req && m_gnt) glog.push_back(m_addr == 32'h100);
            if (if_rvalid) begin
                if_cyc = cyc;
                if (exp_if.size() == 0) check("if_rvalid_unexpected", 1, 0);
                else check("if_rdata", if_rdata, exp_if.pop_front());
            end
            if (d_done) begin
                d_cyc = cyc;
                if (exp_d.size() == 0) check("d_done_unexpected", 1, 0);
                else begin
                    dexp_t e;
                    e = exp_d.pop_front();
                    check("d_misalign", d_misalign, e.mis);
                    if (e.chk) check("d_rdata", d_rdata, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input logic uns);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        d_lwhb = sz; d_swhb = sz; d_lunsigned = uns;
    endtask

    task automatic push_d(input bit chk, input logic [31:0] rd, input logic mis);
        dexp_t e;
        e.chk = chk; e.rdata = rd; e.mis = mis;
        exp_d.push_back(e);
    endtask

    // Waits for n completion pulses; keep=1 re-requests continuously until the last one.
    task automatic run(input int n, input bit keep, input string tag);
        int seen = 0;
        int cycles = 0;
        bit dd, ir;
        while (seen < n && cycles < 100) begin
            @(negedge clk);
            cycles++;
            dd = d_done;
            ir = if_rvalid;
            seen += int'(dd) + int'(ir);
            tick();
            if (seen >= n) begin
                d_req = 1'b0;
                if_req = 1'b0;
            end else if (!keep) begin
                if (dd) d_req = 1'b0;
                if (ir) if_req = 1'b0;
            end
        end
        check({tag, "_pulses"}, seen, n);
    endtask

    task automatic check_quiet(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            check({tag, "_no_if_rvalid"}, if_rvalid, 0);
            check({tag, "_no_d_done"}, d_done, 0);
            check({tag, "_no_m_req"}, m_req, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, m0;
        logic [5:0] pat;
        reset = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        d_lwhb = SZ_W; d_swhb = SZ_W; d_lunsigned = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_req", m_req, 0);
        check("rst_m_be", m_be, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_pulses", {30'h0, d_done, if_rvalid}, 0);
        tick();
        reset = 1'b1;
        tick();

        // Fetch only, minimum latency.
        if_req = 1'b1; if_addr = 32'h100; exp_if.push_back(32'h00500093); t0 = cyc;
        @(negedge clk);
        check("if_c0_m_req", m_req, 0);
        @(negedge clk);
        check("if_c1_m_req", m_req, 1);
        check("if_c1_m_addr", m_addr, 32'h100);
        check("if_c1_m_we", m_we, 0);
        run(1, 0, "if_only");
        check("if_latency", if_cyc - t0, 2);

        // Simultaneous requests: data first, fetch afterwards.
        glog.delete();
        if_req = 1'b1; if_addr = 32'h100; exp_if.push_back(32'h00500093);
        d_issue(0, 32'h200, 0, SZ_W, 0); push_d(1, 32'h80011234, 0);
        run(2, 0, "simul");
        check("simul_grants", glog.size(), 2);
        check("simul_first_is_d", glog[0], 0);
        check("simul_second_is_if", glog[1], 1);
        check("simul_d_before_if", d_cyc < if_cyc, 1);

        // Continuous contention with a streak limit of 2.
        glog.delete();
        if_req = 1'b1; if_addr = 32'h100;
        d_issue(0, 32'h300, 0, SZ_W, 0);
        repeat (4) push_d(1, 32'h11223344, 0);
        repeat (2) exp_if.push_back(32'h00500093);
        run(6, 1, "order");
        pat = '0;
        for (int i = 0; i < 6; i++) pat[5-i] = glog[i];
        check("order_grant_count", glog.size(), 6);
        check("order_pattern_DDIDDI", pat, 6'b001001);

        // Load alignment and extension.
        d_issue(0, 32'h202, 0, SZ_H, 0); push_d(1, 32'hFFFF8001, 0); run(1, 0, "lh");
        d_issue(0, 32'h202, 0, SZ_H, 1); push_d(1, 32'h00008001, 0); run(1, 0, "lhu");
        d_issue(0, 32'h201, 0, SZ_B, 0); push_d(1, 32'h00000012, 0); run(1, 0, "lb");

        // Byte store: lane enable and replication, then read back.
        d_issue(1, 32'h203, 32'h000000AB, SZ_B, 0); push_d(0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("sb_m_req", m_req, 1);
        check("sb_m_we", m_we, 1);
        check("sb_m_be", m_be, 4'b1000);
        check("sb_m_wdata", m_wdata, 32'hABABABAB);
        check("sb_m_addr", m_addr, 32'h200);
        run(1, 0, "sb");
        d_issue(0, 32'h200, 0, SZ_W, 0); push_d(1, 32'hAB011234, 0); run(1, 0, "lw_after_sb");
        d_issue(0, 32'h203, 0, SZ_B, 0); push_d(1, 32'hFFFFFFAB, 0); run(1, 0, "lb_sext");
        d_issue(0, 32'h203, 0, SZ_B, 1); push_d(1, 32'h000000AB, 0); run(1, 0, "lbu");

        // Misaligned word load: pulse one cycle after accept, never reaches the bus.
        m0 = mreq_cnt;
        d_issue(0, 32'h201, 0, SZ_W, 0); push_d(0, 0, 1);
        @(negedge clk);
        check("mis_c0_d_done", d_done, 0);
        @(negedge clk);
        check("mis_c1_d_done", d_done, 1);
        check("mis_c1_d_misalign", d_misalign, 1);
        tick();
        d_req = 1'b0;
        check_quiet(2, "mis_after");
        d_issue(0, 32'h203, 0, SZ_H, 0); push_d(0, 0, 1); run(1, 0, "mis_half");
        check("mis_no_bus_access", mreq_cnt - m0, 0);

        // Flush while waiting for the fetch response.
        hold_rv = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) @(negedge clk);
        tick();
        if_flush = 1'b1; if_req = 1'b0;
        tick();
        if_flush = 1'b0; hold_rv = 1'b0;
        check_quiet(3, "flush_wait");
        if_req = 1'b1; exp_if.push_back(32'h00500093); t0 = cyc;
        run(1, 0, "after_flush");
        check("after_flush_latency", if_cyc - t0, 2);

        // Flush in the same cycle as the fetch response.
        if_req = 1'b1;
        tick();
        tick();
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check("flush_rv_m_rvalid", m_rvalid, 1);
        check("flush_rv_suppressed", if_rvalid, 0);
        tick();
        if_flush = 1'b0;
        check_quiet(2, "flush_rv");

        // Reset while a data access is in its address phase, then in its wait phase.
        gnt_en = 1'b0;
        d_issue(0, 32'h200, 0, SZ_W, 0);
        repeat (3) @(negedge clk);
        check("rst_daddr_m_req_before", m_req, 1);
        reset = 1'b0;
        #1;
        check("rst_daddr_m_req_after", m_req, 0);
        d_req = 1'b0; gnt_en = 1'b1;
        tick();
        reset = 1'b1;
        check_quiet(2, "rst_daddr");
        tick();
        hold_rv = 1'b1;
        d_issue(0, 32'h200, 0, SZ_W, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_dwait_m_req", m_req, 0);
        check("rst_dwait_d_done", d_done, 0);
        d_req = 1'b0; hold_rv = 1'b0;
        tick();
        reset = 1'b1;
        check_quiet(3, "rst_dwait");
        tick();
        d_issue(0, 32'h300, 0, SZ_W, 0); push_d(1, 32'h11223344, 0); run(1, 0, "post_reset");

        check("sb_if_empty", exp_if.size(), 0);
        check("sb_d_empty", exp_d.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
